// File: rtl/ps2_mouse_master_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_master_ctrl
//
// PS/2 mouse host controller. Sits between a PS/2 byte transmitter/receiver
// pair and the bus-side mouse peripheral. After power-up it resets the mouse,
// optionally knocks it into IntelliMouse wheel mode (sample rates 200/100/80
// followed by a Get-ID), enables streaming and then assembles 3- or 4-byte
// movement packets. Each packet is presented atomically with a one-cycle
// interrupt. Failed handshakes retry a bounded number of times before FAIL
// latches.
//
// Ports
//   CLK, RESET        clock, asynchronous active-low reset
//   SEND_BYTE         one-cycle transmit request (first cycle of SEND_CMD)
//   BYTE_TO_SEND      command byte, held while the command is in flight
//   BYTE_SENT         transmitter done pulse
//   READ_ENABLE       receiver enable (registered, follows state by 1 cycle)
//   BYTE_READ         received byte
//   BYTE_ERROR_CODE   receiver error, 2'b00 = ok
//   BYTE_READY        received-byte strobe
//   MOUSE_STATUS/DX/DY/DZ  last complete packet (DZ = 0 outside wheel mode)
//   WHEEL_MODE        device identified itself as ID 0x03
//   SEND_INTERRUPT    one-cycle packet-valid pulse
//   PKT_ERROR         one-cycle pulse when a misframed first byte is dropped
//   FAIL              sticky, retries exhausted
//   STATE             encoded current state (debug)
// ---------------------------------------------------------------------------
module ps2_mouse_master_ctrl #(
  parameter int POWERUP_CYCLES     = 500_000,
  parameter int ACK_TIMEOUT_CYCLES = 500_000,
  parameter int BAT_TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRIES        = 3,
  parameter int ENABLE_WHEEL       = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [3:0] MOUSE_DZ,
  output logic       WHEEL_MODE,
  output logic       SEND_INTERRUPT,
  output logic       PKT_ERROR,
  output logic       FAIL,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_POWERUP  = 4'd0,
    S_SEND_CMD = 4'd1,
    S_WAIT_ACK = 4'd2,
    S_WAIT_BAT = 4'd3,
    S_WAIT_ID0 = 4'd4,
    S_WAIT_ID  = 4'd5,
    S_RETRY    = 4'd6,
    S_FAILED   = 4'd7,
    S_STREAM   = 4'd8
  } state_t;

  localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] BAT_LAST  = 32'(BAT_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

  // Command list. The wheel variant inserts the 200/100/80 sample-rate knock
  // and a Get-ID between the reset and the stream enable.
  function automatic logic [7:0] f_cmd(input logic [3:0] idx);
    logic [7:0] c;
    c = 8'hFF;
    if (ENABLE_WHEEL != 0) begin
      case (idx)
        4'd1, 4'd3, 4'd5: c = 8'hF3;
        4'd2:             c = 8'hC8;
        4'd4:             c = 8'h64;
        4'd6:             c = 8'h50;
        4'd7:             c = 8'hF2;
        4'd8:             c = 8'hF4;
        default:          c = 8'hFF;
      endcase
    end else begin
      c = (idx == 4'd1) ? 8'hF4 : 8'hFF;
    end
    return c;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_retries, w_retries_nxt;
  logic        r_wheel, w_wheel_nxt;
  logic [31:0] r_timer;
  logic [1:0]  r_cnt;
  logic [7:0]  r_b0, r_b1, r_b2;
  logic        r_send, r_rd_en, r_int, r_pkt_err, r_fail;
  logic [7:0]  r_byte, r_status, r_dx, r_dy;
  logic [3:0]  r_dz;

  logic        w_rx_ok, w_timeout, w_enter, w_counting;
  logic [7:0]  w_cur_cmd;
  logic [1:0]  w_last_cnt;

  assign w_rx_ok    = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign w_cur_cmd  = f_cmd(r_idx);
  assign w_enter    = (w_state_nxt != r_state);
  assign w_last_cnt = r_wheel ? 2'd3 : 2'd2;
  assign w_counting = (r_state == S_POWERUP) || (r_state == S_WAIT_ACK) ||
                      (r_state == S_WAIT_BAT) || (r_state == S_WAIT_ID0) ||
                      (r_state == S_WAIT_ID);

  always_comb begin
    w_timeout = 1'b0;
    case (r_state)
      S_POWERUP:                       w_timeout = (r_timer == PWR_LAST);
      S_WAIT_ACK, S_WAIT_ID0, S_WAIT_ID: w_timeout = (r_timer == ACK_LAST);
      S_WAIT_BAT:                      w_timeout = (r_timer == BAT_LAST);
      default:                         w_timeout = 1'b0;
    endcase
  end

  // Next-state logic. In every WAIT_* state a received byte is decided
  // before the timeout, so a byte landing on the timeout cycle still counts.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_retries_nxt = r_retries;
    w_wheel_nxt   = r_wheel;
    case (r_state)
      S_POWERUP: begin
        if (w_timeout) begin
          w_state_nxt = S_SEND_CMD;
          w_idx_nxt   = 4'd0;
        end
      end
      S_SEND_CMD: begin
        if (BYTE_SENT) w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (BYTE_READY) begin
          if (w_rx_ok && BYTE_READ == 8'hFA) begin
            case (w_cur_cmd)
              8'hFF:   w_state_nxt = S_WAIT_BAT;
              8'hF2:   w_state_nxt = S_WAIT_ID;
              8'hF4:   w_state_nxt = S_STREAM;
              default: begin
                w_idx_nxt   = r_idx + 4'd1;
                w_state_nxt = S_SEND_CMD;
              end
            endcase
          end else begin
            w_state_nxt = S_RETRY;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_RETRY;
        end
      end
      S_WAIT_BAT: begin
        if (BYTE_READY)
          w_state_nxt = (w_rx_ok && BYTE_READ == 8'hAA) ? S_WAIT_ID0 : S_RETRY;
        else if (w_timeout)
          w_state_nxt = S_RETRY;
      end
      S_WAIT_ID0: begin
        if (BYTE_READY) begin
          if (w_rx_ok && BYTE_READ == 8'h00) begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = S_SEND_CMD;
          end else begin
            w_state_nxt = S_RETRY;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_RETRY;
        end
      end
      S_WAIT_ID: begin
        if (BYTE_READY) begin
          if (w_rx_ok && (BYTE_READ == 8'h03 || BYTE_READ == 8'h00)) begin
            w_wheel_nxt = (BYTE_READ == 8'h03);
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = S_SEND_CMD;
          end else begin
            w_state_nxt = S_RETRY;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_RETRY;
        end
      end
      S_RETRY: begin
        if (r_retries == RETRY_MAX) begin
          w_state_nxt = S_FAILED;
        end else begin
          w_retries_nxt = r_retries + 8'd1;
          w_idx_nxt     = 4'd0;
          w_wheel_nxt   = 1'b0;
          w_state_nxt   = S_SEND_CMD;
        end
      end
      S_FAILED: w_state_nxt = S_FAILED;
      S_STREAM: begin
        // Receiver error while streaming: full re-initialisation, not a retry.
        if (BYTE_READY && BYTE_ERROR_CODE != 2'b00) begin
          w_idx_nxt     = 4'd0;
          w_retries_nxt = 8'd0;
          w_state_nxt   = S_SEND_CMD;
        end
      end
      default: w_state_nxt = S_POWERUP;
    endcase
    if (w_state_nxt == S_STREAM && r_state != S_STREAM) w_retries_nxt = 8'd0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_POWERUP;
      r_idx     <= 4'd0;
      r_retries <= 8'd0;
      r_wheel   <= 1'b0;
      r_timer   <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_retries <= w_retries_nxt;
      r_wheel   <= w_wheel_nxt;
      if (w_enter)         r_timer <= 32'd0;
      else if (w_counting) r_timer <= r_timer + 32'd1;
    end
  end

  // Command strobe, receiver enable and packet assembly. Packet bytes are
  // staged in r_b* so the visible outputs change only on a complete packet.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_send    <= 1'b0;
      r_byte    <= 8'hFF;
      r_rd_en   <= 1'b0;
      r_int     <= 1'b0;
      r_pkt_err <= 1'b0;
      r_fail    <= 1'b0;
      r_cnt     <= 2'd0;
      r_b0      <= 8'd0;
      r_b1      <= 8'd0;
      r_b2      <= 8'd0;
      r_status  <= 8'd0;
      r_dx      <= 8'd0;
      r_dy      <= 8'd0;
      r_dz      <= 4'd0;
    end else begin
      r_send    <= 1'b0;
      r_int     <= 1'b0;
      r_pkt_err <= 1'b0;
      if (w_enter && w_state_nxt == S_SEND_CMD) begin
        r_send <= 1'b1;
        r_byte <= f_cmd(w_idx_nxt);
      end
      r_rd_en <= !((r_state == S_POWERUP) || (r_state == S_SEND_CMD) ||
                   (r_state == S_FAILED));
      if (w_state_nxt == S_FAILED) r_fail <= 1'b1;
      if (r_state != S_STREAM) begin
        r_cnt <= 2'd0;
      end else if (BYTE_READY) begin
        if (BYTE_ERROR_CODE != 2'b00) begin
          r_cnt <= 2'd0;
        end else if (r_cnt == 2'd0 && !BYTE_READ[3]) begin
          // Status byte always has bit 3 set; anything else is out of sync.
          r_pkt_err <= 1'b1;
        end else if (r_cnt == w_last_cnt) begin
          r_cnt    <= 2'd0;
          r_int    <= 1'b1;
          r_status <= r_b0;
          r_dx     <= r_b1;
          if (r_wheel) begin
            r_dy <= r_b2;
            r_dz <= BYTE_READ[3:0];
          end else begin
            r_dy <= BYTE_READ;
            r_dz <= 4'd0;
          end
        end else begin
          r_cnt <= r_cnt + 2'd1;
          case (r_cnt)
            2'd0:    r_b0 <= BYTE_READ;
            2'd1:    r_b1 <= BYTE_READ;
            default: r_b2 <= BYTE_READ;
          endcase
        end
      end
    end
  end

  assign SEND_BYTE      = r_send;
  assign BYTE_TO_SEND   = r_byte;
  assign READ_ENABLE    = r_rd_en;
  assign MOUSE_STATUS   = r_status;
  assign MOUSE_DX       = r_dx;
  assign MOUSE_DY       = r_dy;
  assign MOUSE_DZ       = r_dz;
  assign WHEEL_MODE     = r_wheel;
  assign SEND_INTERRUPT = r_int;
  assign PKT_ERROR      = r_pkt_err;
  assign FAIL           = r_fail;
  assign STATE          = r_state;

endmodule

// File: tb/tb_ps2_mouse_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_master_ctrl
//
// Two controller instances: index 0 with the wheel knock sequence, index 1
// without. A small device model answers commands and feeds packet bytes.
// Expected commands and packets are queued before the stimulus that causes
// them and are popped by a monitor when the DUT emits them.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_master_ctrl;

  localparam int PWR = 20;
  localparam int ACK = 100;
  localparam int BAT = 300;

  typedef struct { int d; logic [7:0] b; } cmd_t;
  typedef struct { int d; logic [7:0] s, x, y; logic [3:0] z; } pkt_t;

  logic       clk;
  logic       rst_n        [2];
  logic       byte_sent    [2];
  logic [7:0] byte_read    [2];
  logic [1:0] err_code     [2];
  logic       byte_ready   [2];
  logic       send_byte    [2];
  logic [7:0] byte_to_send [2];
  logic       read_en      [2];
  logic [7:0] m_status     [2];
  logic [7:0] m_dx         [2];
  logic [7:0] m_dy         [2];
  logic [3:0] m_dz         [2];
  logic       wheel        [2];
  logic       irq          [2];
  logic       pkt_err      [2];
  logic       fail         [2];
  logic [3:0] state        [2];

  cmd_t cmd_q[$];
  pkt_t pkt_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_send   [2] = '{0, 0};
  int   n_irq    [2] = '{0, 0};
  int   n_perr   [2] = '{0, 0};

  logic [7:0] cmd_w [9] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
  logic [7:0] cmd_n [2] = '{8'hFF, 8'hF4};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ps2_mouse_master_ctrl #(
      .POWERUP_CYCLES    (PWR),
      .ACK_TIMEOUT_CYCLES(ACK),
      .BAT_TIMEOUT_CYCLES(BAT),
      .MAX_RETRIES       (3),
      .ENABLE_WHEEL      ((g == 0) ? 1 : 0)
    ) u_dut (
      .CLK            (clk),
      .RESET          (rst_n[g]),
      .SEND_BYTE      (send_byte[g]),
      .BYTE_TO_SEND   (byte_to_send[g]),
      .BYTE_SENT      (byte_sent[g]),
      .READ_ENABLE    (read_en[g]),
      .BYTE_READ      (byte_read[g]),
      .BYTE_ERROR_CODE(err_code[g]),
      .BYTE_READY     (byte_ready[g]),
      .MOUSE_STATUS   (m_status[g]),
      .MOUSE_DX       (m_dx[g]),
      .MOUSE_DY       (m_dy[g]),
      .MOUSE_DZ       (m_dz[g]),
      .WHEEL_MODE     (wheel[g]),
      .SEND_INTERRUPT (irq[g]),
      .PKT_ERROR      (pkt_err[g]),
      .FAIL           (fail[g]),
      .STATE          (state[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a command or packet.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (send_byte[d] === 1'b1) begin
        cmd_t e;
        n_send[d]++;
        if (cmd_q.size() == 0) begin
          check_val("cmd_unexpected", 32'(byte_to_send[d]), 32'h1FF);
        end else begin
          e = cmd_q.pop_front();
          check_val("cmd_dut", 32'(d), 32'(e.d));
          check_val("cmd_byte", 32'(byte_to_send[d]), 32'(e.b));
        end
      end
      if (irq[d] === 1'b1) begin
        pkt_t p;
        n_irq[d]++;
        if (pkt_q.size() == 0) begin
          check_val("irq_unexpected", 32'(m_status[d]), 32'h1FF);
        end else begin
          p = pkt_q.pop_front();
          check_val("pkt_dut", 32'(d), 32'(p.d));
          check_val("pkt_status", 32'(m_status[d]), 32'(p.s));
          check_val("pkt_dx", 32'(m_dx[d]), 32'(p.x));
          check_val("pkt_dy", 32'(m_dy[d]), 32'(p.y));
          check_val("pkt_dz", 32'(m_dz[d]), 32'(p.z));
        end
      end
      if (pkt_err[d] === 1'b1) n_perr[d]++;
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_send(input int d, input int budget, output int cyc);
    cyc = 0;
    while (send_byte[d] !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check_val("send_seen", 32'(send_byte[d]), 32'd1);
  endtask

  task automatic tx_done(input int d);
    byte_sent[d] = 1'b1;
    @(negedge clk);
    byte_sent[d] = 1'b0;
  endtask

  task automatic rx(input int d, input logic [7:0] b, input logic [1:0] c);
    byte_read[d]  = b;
    err_code[d]   = c;
    byte_ready[d] = 1'b1;
    @(negedge clk);
    byte_ready[d] = 1'b0;
    err_code[d]   = 2'b00;
  endtask

  task automatic feed(input int d, input logic [7:0] b);
    rx(d, b, 2'b00);
    idle(1);
  endtask

  task automatic push_cmds(input int d);
    cmd_t e;
    e.d = d;
    if (d == 0) for (int i = 0; i < 9; i++) begin e.b = cmd_w[i]; cmd_q.push_back(e); end
    else        for (int i = 0; i < 2; i++) begin e.b = cmd_n[i]; cmd_q.push_back(e); end
  endtask

  task automatic push_pkt(input int d, input logic [7:0] s, x, y, input logic [3:0] z);
    pkt_t p;
    p.d = d; p.s = s; p.x = x; p.y = y; p.z = z;
    pkt_q.push_back(p);
  endtask

  // Device model answering the whole init sequence; late_ack delivers the
  // first ACK exactly on the ACK timeout cycle.
  task automatic run_init(input int d, input logic [7:0] id_resp, input bit late_ack);
    int ncmd, cyc;
    logic [7:0] c;
    ncmd = (d == 0) ? 9 : 2;
    for (int i = 0; i < ncmd; i++) begin
      c = (d == 0) ? cmd_w[i] : cmd_n[i];
      wait_send(d, 200, cyc);
      tx_done(d);
      if (late_ack && i == 0) idle(ACK - 1);
      rx(d, 8'hFA, 2'b00);
      if (late_ack && i == 0) check_val("ack_on_timeout", 32'(state[d]), 32'd3);
      if (c == 8'hFF) begin
        idle(2); rx(d, 8'hAA, 2'b00);
        idle(2); rx(d, 8'h00, 2'b00);
      end else if (c == 8'hF2) begin
        idle(1); rx(d, id_resp, 2'b00);
      end
    end
  endtask

  initial begin
    int cyc, base;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; byte_sent[d] = 1'b0; byte_read[d] = 8'h00;
      err_code[d] = 2'b00; byte_ready[d] = 1'b0;
    end
    idle(3);
    // Reset state
    check_val("rst_state", 32'(state[0]), 32'd0);
    check_val("rst_tx_byte", 32'(byte_to_send[0]), 32'hFF);
    check_val("rst_outs", {20'd0, send_byte[0], read_en[0], wheel[0], irq[0],
                           pkt_err[0], fail[0], m_dz[0], 2'd0},
              32'd0);
    check_val("rst_pkt", {m_status[0], m_dx[0], m_dy[0], 8'd0}, 32'd0);

    // Wheel init
    push_cmds(0);
    rst_n[0] = 1'b1;
    wait_send(0, 200, cyc);
    check_val("pwrup_lat", 32'(cyc), 32'(PWR));
    run_init(0, 8'h03, 1'b0);
    check_val("wheel_mode", 32'(wheel[0]), 32'd1);
    check_val("state_stream", 32'(state[0]), 32'd8);
    idle(1);
    check_val("read_en_stream", 32'(read_en[0]), 32'd1);
    check_val("wheel_send_cnt", 32'(n_send[0]), 32'd9);

    // Wheel packet
    base = n_irq[0];
    push_pkt(0, 8'h09, 8'h05, 8'hFB, 4'hF);
    feed(0, 8'h09); feed(0, 8'h05); feed(0, 8'hFB); feed(0, 8'h0F);
    idle(2);
    check_val("irq_once_wheel", 32'(n_irq[0] - base), 32'd1);

    // Framing resync in wheel mode
    base = n_irq[0];
    push_pkt(0, 8'h08, 8'h10, 8'h20, 4'hA);
    feed(0, 8'h01); feed(0, 8'h08); feed(0, 8'h10); feed(0, 8'h20); feed(0, 8'h0A);
    idle(2);
    check_val("perr_once_wheel", 32'(n_perr[0]), 32'd1);
    check_val("irq_after_resync", 32'(n_irq[0] - base), 32'd1);

    // Receiver error in stream, then re-init with ACK on the timeout cycle
    push_cmds(0);
    base = n_perr[0];
    rx(0, 8'h00, 2'b01);
    check_val("err_state", 32'(state[0]), 32'd1);
    check_val("err_tx_byte", 32'(byte_to_send[0]), 32'hFF);
    check_val("err_no_perr", 32'(pkt_err[0]), 32'd0);
    run_init(0, 8'h03, 1'b1);
    idle(2);
    check_val("err_no_perr_cnt", 32'(n_perr[0] - base), 32'd0);
    check_val("reinit_stream", 32'(state[0]), 32'd8);
    check_val("reinit_fail", 32'(fail[0]), 32'd0);

    // Reset mid-packet
    feed(0, 8'h09); feed(0, 8'h11);
    rst_n[0] = 1'b0;
    #1;
    check_val("mid_rst_pkt", {m_status[0], m_dx[0], m_dy[0], 4'd0, m_dz[0]}, 32'd0);
    check_val("mid_rst_ctrl", {26'd0, send_byte[0], read_en[0], wheel[0], irq[0],
                               pkt_err[0], fail[0]}, 32'd0);
    check_val("mid_rst_state", 32'(state[0]), 32'd0);
    check_val("mid_rst_tx", 32'(byte_to_send[0]), 32'hFF);
    idle(2);
    push_cmds(0);
    rst_n[0] = 1'b1;
    run_init(0, 8'h03, 1'b0);
    base = n_irq[0];
    push_pkt(0, 8'h08, 8'h01, 8'h02, 4'h3);
    feed(0, 8'h08); feed(0, 8'h01); feed(0, 8'h02); feed(0, 8'h03);
    idle(2);
    check_val("irq_after_reset", 32'(n_irq[0] - base), 32'd1);

    // Retry exhaustion: no ACKs at all
    rst_n[0] = 1'b0;
    idle(2);
    for (int k = 0; k < 4; k++) cmd_q.push_back('{0, 8'hFF});
    base = n_send[0];
    rst_n[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_send(0, 300, cyc);
      check_val(k == 0 ? "retry_first_lat" : "retry_gap", 32'(cyc),
                k == 0 ? 32'(PWR) : 32'(ACK + 1));
      check_val("fail_early", 32'(fail[0]), 32'd0);
      tx_done(0);
    end
    idle(2 * ACK);
    check_val("fail_set", 32'(fail[0]), 32'd1);
    check_val("fail_state", 32'(state[0]), 32'd7);
    check_val("fail_read_en", 32'(read_en[0]), 32'd0);
    check_val("fail_sends", 32'(n_send[0] - base), 32'd4);

    // No-wheel instance
    push_cmds(1);
    rst_n[1] = 1'b1;
    run_init(1, 8'h00, 1'b0);
    check_val("nw_wheel", 32'(wheel[1]), 32'd0);
    check_val("nw_stream", 32'(state[1]), 32'd8);
    check_val("nw_send_cnt", 32'(n_send[1]), 32'd2);
    push_pkt(1, 8'h08, 8'h01, 8'h02, 4'h0);
    feed(1, 8'h08); feed(1, 8'h01); feed(1, 8'h02);
    idle(2);
    check_val("nw_irq", 32'(n_irq[1]), 32'd1);
    push_pkt(1, 8'h08, 8'h10, 8'h20, 4'h0);
    feed(1, 8'h01); feed(1, 8'h08); feed(1, 8'h10); feed(1, 8'h20);
    idle(2);
    check_val("nw_perr", 32'(n_perr[1]), 32'd1);
    check_val("nw_irq_resync", 32'(n_irq[1]), 32'd2);

    check_val("cmd_q_left", 32'(cmd_q.size()), 32'd0);
    check_val("pkt_q_left", 32'(pkt_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_master_ctrl.md
Name: ps2_mouse_master_ctrl

Overview:
- Parametrised PS/2 mouse host controller. It sits between the PS/2 transmitter/receiver pair and the bus-side mouse peripheral.
- Runs the full initialisation sequence with timeout and bounded retry, and optionally enables IntelliMouse wheel mode through the sample-rate knock sequence.
- Assembles 3- or 4-byte stream packets with framing checks, then presents each packet atomically with a one-cycle interrupt.

Parameters:
- POWERUP_CYCLES, 500_000: idle delay after reset before the first command (10 ms at 50 MHz).
- ACK_TIMEOUT_CYCLES, 500_000: maximum wait for an ACK or ID byte.
- BAT_TIMEOUT_CYCLES, 50_000_000: maximum wait for the 0xAA self-test byte.
- MAX_RETRIES, 3: number of re-initialisations allowed before FAIL is asserted.
- ENABLE_WHEEL, 1: 1 inserts the wheel knock sequence; 0 sends only FF then F4.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- SEND_BYTE  out  1  one-cycle transmit request
- BYTE_TO_SEND  out  8  command byte
- BYTE_SENT  in  1  transmitter done pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error; 00 means ok
- BYTE_READY  in  1  received-byte strobe
- MOUSE_STATUS  out  8  packet byte 0
- MOUSE_DX  out  8  packet byte 1
- MOUSE_DY  out  8  packet byte 2
- MOUSE_DZ  out  4  packet byte 3 [3:0]; 0 when not in wheel mode
- WHEEL_MODE  out  1  device answered ID 0x03
- SEND_INTERRUPT  out  1  one-cycle packet-valid pulse
- PKT_ERROR  out  1  one-cycle pulse on a framing drop
- FAIL  out  1  sticky; retries exhausted
- STATE  out  4  encoded current state (debug)

Behaviour:
- Reset values:
  - State is POWERUP.
  - All outputs are 0, except BYTE_TO_SEND = 0xFF.
  - Retry count, command index, timer and byte count are all 0.
- Command list, indexed by idx:
  - ENABLE_WHEEL=1: FF, F3, C8, F3, 64, F3, 50, F2, F4.
  - ENABLE_WHEEL=0: FF, F4.
- States:
  - POWERUP: when timer == POWERUP_CYCLES-1, go to SEND_CMD with idx=0.
  - SEND_CMD:
    - SEND_BYTE pulses high for exactly the first cycle in the state.
    - BYTE_TO_SEND is set to cmd[idx] on that cycle and held until leaving.
    - On BYTE_SENT, go to WAIT_ACK.
  - WAIT_ACK:
    - BYTE_READY with code 00 and byte 0xFA:
      - If cmd was FF, go to WAIT_BAT.
      - If cmd was F2, go to WAIT_ID.
      - If cmd was F4, go to STREAM.
      - Otherwise increment idx and go to SEND_CMD.
    - Any other byte, error code, or timeout goes to the RETRY path.
  - WAIT_BAT:
    - 0xAA goes to WAIT_ID0.
    - Anything else, or BAT timeout, goes to RETRY.
  - WAIT_ID0:
    - 0x00 increments idx and goes to SEND_CMD.
    - Anything else, or timeout, goes to RETRY.
  - WAIT_ID (after F2):
    - 0x03 sets WHEEL_MODE=1.
    - 0x00 sets WHEEL_MODE=0.
    - In both cases, increment idx and go to SEND_CMD.
    - Any other value, or timeout, goes to RETRY.
  - RETRY:
    - If retries == MAX_RETRIES, go to FAILED.
    - Otherwise retries++, idx=0, WHEEL_MODE=0, go to SEND_CMD.
  - FAILED: FAIL=1; the state is left only by RESET.
  - STREAM: packet assembly (see below).
- Timer:
  - Cleared on every state entry.
  - Counts every cycle while in POWERUP and in the WAIT_* states.
  - Timeout fires at count == limit-1.
  - If BYTE_READY and timeout occur in the same cycle, BYTE_READY takes priority.
- READ_ENABLE is 0 in POWERUP, SEND_CMD and FAILED, and 1 in all other states. It is registered and updated on the cycle after each state change.
- Retry count is cleared on entry to STREAM.
- STREAM packet assembly:
  - PKT_LEN is 4 when WHEEL_MODE=1, else 3.
  - Byte count cnt advances on each good BYTE_READY and wraps at PKT_LEN-1.
  - Framing: at cnt=0, a byte with bit3=0 is dropped, PKT_ERROR pulses, and cnt stays 0.
  - On the final byte, STATUS/DX/DY/DZ update together on the next cycle and SEND_INTERRUPT pulses on that same cycle. DZ is 0 when PKT_LEN=3.
  - Output registers hold their value between packets.
  - BYTE_READY with a nonzero code gives cnt=0, retries=0, idx=0, and goes to SEND_CMD. This is a full re-initialisation; it does not count as a retry and does not change FAIL.
- Reset asserted mid-operation gives an immediate return to all reset values, and any partial packet is discarded.

Test Plan:
- Wheel init: ENABLE_WHEEL=1 and device answers FA, AA, 00, then FA to each command, with F2 answered FA then 03.
  - Required: 9 SEND_BYTE pulses with bytes FF, F3, C8, F3, 64, F3, 50, F2, F4 in that order.
  - Required: WHEEL_MODE=1 and STATE=STREAM.
- Stream packets:
  - In wheel mode, feed 0x09, 0x05, 0xFB, 0x0F. Required: SEND_INTERRUPT for 1 cycle; STATUS=09, DX=05, DY=FB, DZ=F.
  - With ENABLE_WHEEL=0, feed 0x08, 0x01, 0x02. Required: interrupt after the 3rd byte; DZ=0.
- Framing resync: feed 0x01 at cnt=0, then 0x08, 0x10, 0x20.
  - Required: one PKT_ERROR pulse, then a single interrupt with STATUS=08, DX=10, DY=20.
- Retry and fail: withhold all ACKs with MAX_RETRIES=3 and ACK_TIMEOUT_CYCLES=100.
  - Required: 4 FF sends spaced by timeouts, then FAIL=1 and no further SEND_BYTE.
- Error and priority:
  - First, issue BYTE_READY with code 01 in STREAM. Required: PKT_ERROR not pulsed and SEND_CMD reached with BYTE_TO_SEND=FF.
  - Next, issue BYTE_READY with FA on the exact timeout cycle. Required: the ACK is accepted.
  - Finally, drop RESET after the 2nd byte of a packet. Required: all outputs return to 0.
